inst_mem_ctrl: RTL and testbench

INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

---
 rtl/inst_mem_pkg.sv | 32 +++
 rtl/inst_mem_array.sv | 34 +++
 rtl/inst_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_inst_mem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory controller.
// Holds the fetch FSM state encoding and the byte-to-word packing helper.
package inst_mem_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // bytes[0] is the byte at the fetch address, bytes[3] the one at addr+3.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [WORD_BYTES-1:0][BYTE_W-1:0] bytes,
        input logic                              big_endian
    );
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (big_endian) begin
                w[WORD_W-1-BYTE_W*i -: BYTE_W] = bytes[i];
            end else begin
                w[BYTE_W*i +: BYTE_W] = bytes[i];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Byte-wide program store: one synchronous write port, one asynchronous
// four-consecutive-byte read port. Contents are deliberately never reset.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 waddr,
    input  logic [BYTE_W-1:0]                 wdata,
    input  logic [ADDR_W-1:0]                 raddr,
    output logic [WORD_BYTES-1:0][BYTE_W-1:0] rbytes
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Address wraps modulo the depth; out-of-range fetches are masked upstream.
    always_comb begin
        rbytes = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            rbytes[i] = mem[raddr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction fetch controller: accepts one word fetch at a time, inserts
// WAIT_STATES cycles, then presents a one-cycle response with fault checking.
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BYTE_W-1:0] ld_data,
    input  logic              req,
    input  logic [31:0]       addr,
    output logic              busy,
    output logic              valid,
    output logic [WORD_W-1:0] rdata,
    output logic              fault
);

    localparam logic [3:0]  CNT_INIT   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [32:0] ADDR_LIMIT = (33'd1 << ADDR_W) - 33'd4;

    state_e                            state_q, state_d;
    logic [3:0]                        cnt_q, cnt_d;
    logic [ADDR_W-1:0]                 addr_q, addr_d;
    logic                              pend_fault_q, pend_fault_d;
    logic [WORD_W-1:0]                 rdata_q, rdata_d;
    logic                              fault_q, fault_d;

    logic                              accept;
    logic                              req_fault;
    logic                              resp_fault;
    logic [ADDR_W-1:0]                 raddr;
    logic [WORD_BYTES-1:0][BYTE_W-1:0] rbytes;

    assign accept    = (state_q == StIdle) && req;
    assign req_fault = (addr[1:0] != 2'b00) || ({1'b0, addr} > ADDR_LIMIT);

    // With zero wait states the response is read on the accepting edge itself,
    // so the live request fields are used while still idle.
    assign raddr      = (state_q == StIdle) ? addr[ADDR_W-1:0] : addr_q;
    assign resp_fault = (state_q == StIdle) ? req_fault : pend_fault_q;

    inst_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .we     (ld_en),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr  (raddr),
        .rbytes (rbytes)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            pend_fault_q <= 1'b0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            pend_fault_q <= pend_fault_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = (WAIT_STATES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        pend_fault_d = pend_fault_q;
        rdata_d      = rdata_q;
        fault_d      = fault_q;

        if (accept) begin
            cnt_d        = CNT_INIT;
            addr_d       = addr[ADDR_W-1:0];
            pend_fault_d = req_fault;
        end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        // RESP always exits after one cycle, so state_d == StResp means entering it.
        if (state_d == StResp) begin
            rdata_d = resp_fault ? '0 : pack_word(rbytes, BIG_ENDIAN);
            fault_d = resp_fault;
        end
    end

    always_comb begin
        busy  = (state_q != StIdle);
        valid = (state_q == StResp);
        rdata = rdata_q;
        fault = fault_q;
    end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench: four controller instances with different wait-state
// and endianness settings share one clock, reset and preload bus.
module tb_inst_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        req_v   [4];
    logic [31:0] addr_v  [4];
    logic        busy_w  [4];
    logic        valid_w [4];
    logic [31:0] rdata_w [4];
    logic        fault_w [4];

    int total_cnt;
    int pass_cnt;

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] rd;
        logic        f;
    } vec_t;

    vec_t vecs [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inst_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(1), .BIG_ENDIAN(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .req(req_v[0]), .addr(addr_v[0]), .busy(busy_w[0]), .valid(valid_w[0]),
        .rdata(rdata_w[0]), .fault(fault_w[0]));
    inst_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(1), .BIG_ENDIAN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .req(req_v[1]), .addr(addr_v[1]), .busy(busy_w[1]), .valid(valid_w[1]),
        .rdata(rdata_w[1]), .fault(fault_w[1]));
    inst_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(3), .BIG_ENDIAN(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .req(req_v[2]), .addr(addr_v[2]), .busy(busy_w[2]), .valid(valid_w[2]),
        .rdata(rdata_w[2]), .fault(fault_w[2]));
    inst_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(0), .BIG_ENDIAN(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .req(req_v[3]), .addr(addr_v[3]), .busy(busy_w[3]), .valid(valid_w[3]),
        .rdata(rdata_w[3]), .fault(fault_w[3]));

    function automatic int ws_of(input int d);
        case (d)
            0, 1:    return 1;
            2:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] dt);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = dt;
    endtask

    // One complete fetch; addr is scrambled after acceptance to prove it was captured.
    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_f, input string nm);
        int lat;
        bit got;
        logic [31:0] held;
        @(negedge clk);
        req_v[d]  = 1'b1;
        addr_v[d] = a;
        @(negedge clk);
        req_v[d]  = 1'b0;
        addr_v[d] = ~a;
        check({nm, " busy"}, 32'(busy_w[d]), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (valid_w[d]) begin
                got = 1'b1;
            end else begin
                lat++;
                @(negedge clk);
            end
        end
        check({nm, " latency"}, 32'(lat), 32'(ws_of(d)));
        if (got) begin
            check({nm, " rdata"}, rdata_w[d], exp_d);
            check({nm, " fault"}, 32'(fault_w[d]), 32'(exp_f));
            held = rdata_w[d];
            @(negedge clk);
            check({nm, " valid drop"}, 32'(valid_w[d]), 32'd0);
            check({nm, " rdata hold"}, rdata_w[d], exp_d);
            check({nm, " held nonzero-agree"}, held, exp_d);
        end
    endtask

    initial begin
        int          nvalid;
        logic [31:0] seen;
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        for (int d = 0; d < 4; d++) begin
            req_v[d]  = 1'b0;
            addr_v[d] = '0;
        end

        vecs[0]  = '{d: 0, a: 32'h0000_0000, rd: 32'hE3A0_1005, f: 1'b0};
        vecs[1]  = '{d: 1, a: 32'h0000_0004, rd: 32'h0120_81E2, f: 1'b0};
        vecs[2]  = '{d: 0, a: 32'h0000_0002, rd: 32'h0000_0000, f: 1'b1};
        vecs[3]  = '{d: 0, a: 32'h0000_0100, rd: 32'h0000_0000, f: 1'b1};
        vecs[4]  = '{d: 0, a: 32'h0000_0004, rd: 32'hE281_2001, f: 1'b0};
        vecs[5]  = '{d: 1, a: 32'h0000_0000, rd: 32'h0510_A0E3, f: 1'b0};
        vecs[6]  = '{d: 2, a: 32'h0000_0000, rd: 32'hE3A0_1005, f: 1'b0};
        vecs[7]  = '{d: 3, a: 32'h0000_0004, rd: 32'hE281_2001, f: 1'b0};
        vecs[8]  = '{d: 0, a: 32'h0000_00FC, rd: 32'h1122_3344, f: 1'b0};
        vecs[9]  = '{d: 1, a: 32'h0000_00FC, rd: 32'h4433_2211, f: 1'b0};
        vecs[10] = '{d: 0, a: 32'hFFFF_FFFC, rd: 32'h0000_0000, f: 1'b1};
        vecs[11] = '{d: 3, a: 32'h0000_00FD, rd: 32'h0000_0000, f: 1'b1};

        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset busy u%0d", d), 32'(busy_w[d]), 32'd0);
            check($sformatf("reset valid u%0d", d), 32'(valid_w[d]), 32'd0);
            check($sformatf("reset fault u%0d", d), 32'(fault_w[d]), 32'd0);
            check($sformatf("reset rdata u%0d", d), rdata_w[d], 32'd0);
        end
        rst_n = 1'b1;

        load(8'h00, 8'hE3); load(8'h01, 8'hA0); load(8'h02, 8'h10); load(8'h03, 8'h05);
        load(8'h04, 8'hE2); load(8'h05, 8'h81); load(8'h06, 8'h20); load(8'h07, 8'h01);
        load(8'hFC, 8'h11); load(8'hFD, 8'h22); load(8'hFE, 8'h33); load(8'hFF, 8'h44);
        @(negedge clk);
        ld_en = 1'b0;

        for (int i = 0; i < 12; i++) begin
            fetch(vecs[i].d, vecs[i].a, vecs[i].rd, vecs[i].f, $sformatf("vec%0d", i));
        end

        // Second request while busy must be dropped.
        @(negedge clk);
        req_v[0]  = 1'b1;
        addr_v[0] = 32'h0;
        @(negedge clk);
        nvalid = 0;
        seen   = '0;
        for (int i = 0; i < 10; i++) begin
            if (valid_w[0]) begin
                nvalid++;
                seen = rdata_w[0];
            end
            if (i == 0) addr_v[0] = 32'h4;
            if (i == 1) req_v[0] = 1'b0;
            @(negedge clk);
        end
        check("busy drop count", 32'(nvalid), 32'd1);
        check("busy drop rdata", seen, 32'hE3A0_1005);

        // Reset during WAIT kills the fetch; preload survives.
        @(negedge clk);
        req_v[2]  = 1'b1;
        addr_v[2] = 32'h0;
        @(negedge clk);
        req_v[2] = 1'b0;
        check("mid busy", 32'(busy_w[2]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async busy", 32'(busy_w[2]), 32'd0);
        check("async valid", 32'(valid_w[2]), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid_w[2]) nvalid++;
            @(negedge clk);
        end
        check("post reset no valid", 32'(nvalid), 32'd0);
        fetch(2, 32'h4, 32'hE281_2001, 1'b0, "after reset");

        // Write on the response edge returns the old byte.
        @(negedge clk);
        req_v[3]  = 1'b1;
        addr_v[3] = 32'h0;
        ld_en     = 1'b1;
        ld_addr   = 8'h00;
        ld_data   = 8'hFF;
        @(negedge clk);
        req_v[3] = 1'b0;
        ld_en    = 1'b0;
        check("same edge valid", 32'(valid_w[3]), 32'd1);
        check("same edge old byte", rdata_w[3], 32'hE3A0_1005);
        fetch(3, 32'h0, 32'hFFA0_1005, 1'b0, "new byte");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
